// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard emulator: buffers scan-code bytes in a FIFO and
// serializes each as an 11-bit frame (start, D0..D7, odd parity, stop).
module ps2_keyboard_tx #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ps2_clk,
    output logic                     ps2_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PH_W  = $clog2(2 * CLK_DIV);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

    state_t             r_state, w_state_n;
    logic [10:0]        r_frame, w_frame_n;
    logic [3:0]         r_idx, w_idx_n, w_idx_inc;
    logic [PH_W-1:0]    r_phase, w_phase_n, w_phase_inc;
    logic [GAP_W-1:0]   r_gap, w_gap_n;
    logic               r_ps2_clk, w_clk_n;
    logic               r_ps2_data, w_data_n;
    logic               r_busy, w_busy_n;
    logic               r_in_ready, w_in_ready_n;
    logic [7:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr, w_wptr_n, r_rptr, w_rptr_n;
    logic [CNT_W-1:0]   r_count, w_count_n;
    logic               w_push, w_pop;

    // Next-state, next-output and FIFO bookkeeping.
    always_comb begin
        w_push       = in_valid && r_in_ready;
        w_pop        = (r_state == ST_IDLE) && (r_count != CNT_W'(0));
        w_state_n    = r_state;
        w_frame_n    = r_frame;
        w_idx_n      = r_idx;
        w_phase_n    = r_phase;
        w_gap_n      = r_gap;
        w_clk_n      = 1'b1;
        w_data_n     = 1'b1;
        w_phase_inc  = r_phase + PH_W'(1);
        w_idx_inc    = r_idx + 4'd1;

        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_frame_n = make_frame(r_mem[r_rptr]);
                    w_idx_n   = 4'd0;
                    w_phase_n = PH_W'(0);
                    w_state_n = ST_SEND;
                    w_data_n  = 1'b0;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (r_phase == PH_LAST) begin
                    w_phase_n = PH_W'(0);
                    if (r_idx == 4'd10) begin
                        w_state_n = ST_GAP;
                        w_gap_n   = GAP_W'(0);
                    end else begin
                        // Data moves only together with the rising clock.
                        w_idx_n  = w_idx_inc;
                        w_data_n = r_frame[w_idx_inc];
                    end
                end else begin
                    w_phase_n = w_phase_inc;
                    w_clk_n   = (w_phase_inc < PH_HALF);
                    w_data_n  = r_ps2_data;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_gap_n = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        w_busy_n = (w_state_n != ST_IDLE);
        w_wptr_n = w_push ? (r_wptr + PTR_W'(1)) : r_wptr;
        w_rptr_n = w_pop  ? (r_rptr + PTR_W'(1)) : r_rptr;

        case ({w_push, w_pop})
            2'b10:   w_count_n = r_count + CNT_W'(1);
            2'b01:   w_count_n = r_count - CNT_W'(1);
            default: w_count_n = r_count;
        endcase
        w_in_ready_n = (w_count_n != CNT_FULL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_frame    <= 11'h7FF;
            r_idx      <= 4'd0;
            r_phase    <= PH_W'(0);
            r_gap      <= GAP_W'(0);
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_wptr     <= PTR_W'(0);
            r_rptr     <= PTR_W'(0);
            r_count    <= CNT_W'(0);
        end else begin
            r_state    <= w_state_n;
            r_frame    <= w_frame_n;
            r_idx      <= w_idx_n;
            r_phase    <= w_phase_n;
            r_gap      <= w_gap_n;
            r_ps2_clk  <= w_clk_n;
            r_ps2_data <= w_data_n;
            r_busy     <= w_busy_n;
            r_in_ready <= w_in_ready_n;
            r_wptr     <= w_wptr_n;
            r_rptr     <= w_rptr_n;
            r_count    <= w_count_n;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    assign in_ready   = r_in_ready;
    assign ps2_clk    = r_ps2_clk;
    assign ps2_data   = r_ps2_data;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed self-checking bench for ps2_keyboard_tx: default instance plus a
// CLK_DIV=2 / GAP=1 instance, observed through one frame decoder.
module tb_ps2_keyboard_tx;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] in_data;
    logic       a_valid, b_valid;
    logic       sel;

    logic       a_ready, a_clk, a_data, a_busy;
    logic [3:0] a_count;
    logic       b_ready, b_clk, b_data, b_busy;
    logic [3:0] b_count;

    always #5 clk = ~clk;

    ps2_keyboard_tx #(.CLK_DIV(4), .GAP(8), .DEPTH(8)) u_dut_a (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(a_valid),
        .in_ready(a_ready), .ps2_clk(a_clk), .ps2_data(a_data),
        .busy(a_busy), .fifo_count(a_count)
    );

    ps2_keyboard_tx #(.CLK_DIV(2), .GAP(1), .DEPTH(8)) u_dut_b (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(b_valid),
        .in_ready(b_ready), .ps2_clk(b_clk), .ps2_data(b_data),
        .busy(b_busy), .fifo_count(b_count)
    );

    wire m_c    = sel ? b_clk  : a_clk;
    wire m_d    = sel ? b_data : a_data;
    wire m_busy = sel ? b_busy : a_busy;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          falls    = 0;
    int          busy_cyc = 0;
    int          viol     = 0;
    int          bitcnt   = 0;
    bit          mon_en   = 1'b0;
    logic        prev_c   = 1'b1;
    logic        prev_d   = 1'b1;
    logic [10:0] word;
    logic [10:0] rx_q[$];
    int          frame_t[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Receiver model: decode frames on ps2_clk falling edges and watch line rules.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            if (!resetn) begin
                bitcnt = 0;
            end else begin
                if (m_d !== prev_d && m_c !== 1'b1) viol++;
                if (!m_busy && !(m_c === 1'b1 && m_d === 1'b1)) viol++;
                if (m_busy) busy_cyc++;
                if (prev_c === 1'b1 && m_c === 1'b0) begin
                    falls++;
                    if (bitcnt == 0) frame_t.push_back(cyc);
                    word[bitcnt] = m_d;
                    if (bitcnt == 10) begin
                        rx_q.push_back(word);
                        bitcnt = 0;
                    end else begin
                        bitcnt++;
                    end
                end
            end
            prev_c = m_c;
            prev_d = m_d;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_eq("rx_timeout", 32'(rx_q.size() >= n), 32'd1);
        k = 0;
        while (m_busy && k < budget) begin
            tick(1);
            k++;
        end
        check_eq("idle_timeout", 32'(m_busy), 32'd0);
    endtask

    initial begin
        int base_rx, base_f, base_b, base_t, acc, k;
        logic [7:0] exp_q[$];

        sel     = 1'b0;
        in_data = 8'h00;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;

        check_eq("rst_clk",   32'(a_clk),   32'd1);
        check_eq("rst_data",  32'(a_data),  32'd1);
        check_eq("rst_busy",  32'(a_busy),  32'd0);
        check_eq("rst_count", 32'(a_count), 32'd0);
        check_eq("rst_ready", 32'(a_ready), 32'd1);

        // Single byte 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1.
        base_rx = rx_q.size(); base_f = falls; base_b = busy_cyc;
        in_data = 8'h1C; a_valid = 1'b1; tick(1); a_valid = 1'b0;
        wait_rx(base_rx + 1, 400);
        check_eq("frame_1c", 32'(rx_q[base_rx]), 32'h438);
        check_eq("falls_1c", 32'(falls - base_f), 32'd11);
        check_eq("busy_1c",  32'(busy_cyc - base_b), 32'd96);

        // Back-to-back 0xF0, 0x00.
        base_rx = rx_q.size(); base_f = falls; base_t = frame_t.size();
        in_data = 8'hF0; a_valid = 1'b1; tick(1);
        in_data = 8'h00; tick(1); a_valid = 1'b0;
        wait_rx(base_rx + 2, 600);
        check_eq("frame_f0", 32'(rx_q[base_rx]),     32'h7E0);
        check_eq("frame_00", 32'(rx_q[base_rx + 1]), 32'h600);
        check_eq("falls_2",  32'(falls - base_f),    32'd22);
        check_eq("period_a", 32'(frame_t[base_t + 1] - frame_t[base_t]), 32'd97);

        // Fill from reset with continuous valid.
        do_reset();
        base_rx = rx_q.size();
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_data = 8'hA0 + 8'(acc);
            a_valid = 1'b1;
            if (a_ready) begin
                exp_q.push_back(in_data);
                acc++;
            end
            tick(1);
        end
        a_valid = 1'b0;
        check_eq("fill_acc",   32'(acc),     32'd9);
        check_eq("fill_count", 32'(a_count), 32'd8);
        check_eq("fill_ready", 32'(a_ready), 32'd0);
        wait_rx(base_rx + 9, 2000);
        for (int i = 0; i < 9; i++) begin
            check_eq("fill_byte", 32'(rx_q[base_rx + i][8:1]), 32'(exp_q[i]));
            check_eq("fill_par",  32'(^rx_q[base_rx + i][9:1]), 32'd1);
        end

        // Reset mid-frame after the 5th falling edge.
        base_rx = rx_q.size(); base_f = falls;
        in_data = 8'h55; a_valid = 1'b1; tick(1);
        in_data = 8'h66; tick(1);
        in_data = 8'h77; tick(1); a_valid = 1'b0;
        k = 0;
        while (falls - base_f < 5 && k < 300) begin
            tick(1);
            k++;
        end
        check_eq("mid_wait", 32'(falls - base_f >= 5), 32'd1);
        resetn = 1'b0; tick(1); resetn = 1'b1;
        check_eq("mid_clk",   32'(a_clk),   32'd1);
        check_eq("mid_data",  32'(a_data),  32'd1);
        check_eq("mid_busy",  32'(a_busy),  32'd0);
        check_eq("mid_count", 32'(a_count), 32'd0);
        base_f = falls;
        tick(200);
        check_eq("mid_nofall", 32'(falls - base_f), 32'd0);
        check_eq("mid_norx",   32'(rx_q.size() - base_rx), 32'd0);

        // Fast instance: CLK_DIV=2, GAP=1.
        sel = 1'b1;
        tick(1);
        base_rx = rx_q.size(); base_t = frame_t.size(); base_b = busy_cyc;
        in_data = 8'h5A; b_valid = 1'b1; tick(1);
        in_data = 8'h3C; tick(1); b_valid = 1'b0;
        wait_rx(base_rx + 2, 400);
        check_eq("frame_5a", 32'(rx_q[base_rx]),     32'h6B4);
        check_eq("frame_3c", 32'(rx_q[base_rx + 1]), 32'h678);
        check_eq("period_b", 32'(frame_t[base_t + 1] - frame_t[base_t]), 32'd46);
        check_eq("busy_b",   32'(busy_cyc - base_b), 32'd90);

        check_eq("stability", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
